// File: rtl/rc_charge_control_if.sv
// Sample-strobe / control-voltage bundle between the RC charge network and its consumer.
// The master side issues strobes and the charge gate; the slave side returns the voltage and status.
interface rc_charge_control_if;
    logic               audio_clk_en;
    logic               charge;
    logic signed [15:0] out;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    modport master (
        output audio_clk_en,
        output charge,
        input  out,
        input  out_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  audio_clk_en,
        input  charge,
        output out,
        output out_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/rc_charge_control.sv
// RC charge/discharge control-voltage generator: one forward-Euler exponential step per
// audio sample, using a 16-cycle serial shift-add multiply of |target - out| by a Q0.16 coefficient.
module rc_charge_control #(
    parameter int unsigned        CLOCK_RATE   = 50000000,
    parameter int unsigned        SAMPLE_RATE  = 48000,
    parameter int unsigned        R_CHARGE     = 47000,
    parameter int unsigned        R_DISCHARGE  = 10000,
    parameter int unsigned        C_35_SHIFTED = 1134,
    parameter logic signed [15:0] V_HIGH       = 16'sd32767,
    parameter logic signed [15:0] V_LOW        = 16'sd0
) (
    input logic                clk,
    input logic                reset,
    rc_charge_control_if.slave bus
);

    // Q0.16 step fraction = 1/(fs*R*C), with C carried as farads * 2^35.
    function automatic logic [15:0] coef(input longint unsigned r);
        longint unsigned den;
        longint unsigned q;
        den = longint'(SAMPLE_RATE) * r * longint'(C_35_SHIFTED);
        if (den == 0) q = 65535;
        else          q = (64'd1 << 51) / den;
        if (q > 65535)    return 16'hFFFF;
        else if (q == 0)  return 16'd1;
        else              return q[15:0];
    endfunction

    localparam logic [15:0] K_CHG = coef(longint'(R_CHARGE));
    localparam logic [15:0] K_DIS = coef(longint'(R_DISCHARGE));

    // Scale the product back by 2^16; negative steps floor, and a non-zero error always moves by at least one LSB.
    function automatic logic signed [17:0] round_step(input logic [32:0] a,
                                                      input logic        negf,
                                                      input logic        nz);
        logic signed [17:0] s;
        logic signed [17:0] q;
        q = $signed({1'b0, a[32:16]});
        if (negf) s = -q - $signed({17'd0, |a[15:0]});
        else      s = q;
        if (nz && s == 18'sd0) s = negf ? -18'sd1 : 18'sd1;
        return s;
    endfunction

    function automatic logic signed [15:0] clamp_out(input logic signed [18:0] v,
                                                     input logic signed [15:0] tgt,
                                                     input logic               negf);
        logic signed [18:0] r;
        logic signed [18:0] t;
        logic signed [18:0] lo;
        logic signed [18:0] hi;
        r  = v;
        t  = $signed({{3{tgt[15]}}, tgt});
        lo = $signed({{3{V_LOW[15]}}, V_LOW});
        hi = $signed({{3{V_HIGH[15]}}, V_HIGH});
        if (!negf && r > t) r = t;
        if (negf && r < t)  r = t;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r[15:0];
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [15:0]        k_sh;
    logic [32:0]        mcand;
    logic [32:0]        acc;
    logic               neg;
    logic               diff_nz;
    logic signed [15:0] target;
    logic signed [15:0] out_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               overrun_r;

    logic signed [15:0] tgt_sel;
    logic signed [16:0] diff;
    logic [16:0]        mag;
    logic signed [17:0] step;
    logic signed [18:0] sum;
    logic signed [15:0] out_next;

    always_comb begin
        tgt_sel  = bus.charge ? V_HIGH : V_LOW;
        diff     = $signed({tgt_sel[15], tgt_sel}) - $signed({out_r[15], out_r});
        mag      = diff[16] ? 17'(-diff) : 17'(diff);
        step     = round_step(acc, neg, diff_nz);
        sum      = $signed({{3{out_r[15]}}, out_r}) + $signed({step[17], step});
        out_next = clamp_out(sum, target, neg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            k_sh        <= 16'd0;
            mcand       <= 33'd0;
            acc         <= 33'd0;
            neg         <= 1'b0;
            diff_nz     <= 1'b0;
            target      <= V_LOW;
            out_r       <= V_LOW;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (bus.audio_clk_en && state != IDLE) overrun_r <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.audio_clk_en) begin
                        target  <= tgt_sel;
                        k_sh    <= bus.charge ? K_CHG : K_DIS;
                        mcand   <= {16'd0, mag};
                        acc     <= 33'd0;
                        neg     <= diff[16];
                        diff_nz <= (diff != 17'sd0);
                        cnt     <= 4'd0;
                        busy_r  <= 1'b1;
                        state   <= MUL;
                    end
                end
                // one coefficient bit per cycle, multiplicand pre-shifted to weight 2^i
                MUL: begin
                    if (k_sh[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    k_sh  <= k_sh >> 1;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= APPLY;
                end
                APPLY: begin
                    out_r       <= out_next;
                    out_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = overrun_r;

endmodule
